// File: rtl/ring_step_sequencer_if.sv
// ring_step_sequencer_if: switch/button inputs and step outputs of the ring step sequencer.
interface ring_step_sequencer_if;
    logic       en;
    logic       dir;
    logic [1:0] speed;
    logic       pause_btn;
    logic       step_btn;
    logic [2:0] state;
    logic       step_pulse;
    logic       running;
    modport master (output en, dir, speed, pause_btn, step_btn, input state, step_pulse, running);
    modport slave (input en, dir, speed, pause_btn, step_btn, output state, step_pulse, running);
endinterface

// File: rtl/ring_step_sequencer.sv
// ring_step_sequencer: prescaled 3-bit step index with RUN/PAUSE mode and debounced pause/step buttons.
module ring_step_sequencer #(
    parameter int unsigned BASE_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input logic                  clk,
    input logic                  rst_n,
    ring_step_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(BASE_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} mode_t;

    mode_t             mode_q, mode_d;
    logic [1:0]        s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, press;
    logic [1:0][DW-1:0] db_q, db_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        state_q, state_d;
    logic              pulse_q, pulse_d;
    logic [31:0]       div;
    logic              counting, tick, adv;

    // Bit 0 is the pause button, bit 1 the step button.
    always_comb begin
        s1_d = {bus.step_btn, bus.pause_btn};
        s2_d = s1_q;
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = (s2_q[i] != lvl_q[i] && db_q[i] != DB_LAST) ? db_q[i] + 1'b1 : '0;
            lvl_d[i] = (s2_q[i] != lvl_q[i] && db_q[i] == DB_LAST) ? s2_q[i] : lvl_q[i];
            press[i] = s2_q[i] && !lvl_q[i] && db_q[i] == DB_LAST;
        end
        div      = BASE_DIV >> bus.speed;
        counting = bus.en && mode_q == RUN;
        tick     = counting && 32'(cnt_q) >= div - 32'd1;
        mode_d   = press[0] ? (mode_q == RUN ? PAUSE : RUN) : mode_q;
        cnt_d    = (tick || (mode_q == PAUSE && mode_d == RUN)) ? '0 : counting ? cnt_q + 1'b1 : cnt_q;
        adv      = bus.en && !press[0] && (mode_q == RUN ? tick : press[1]);
        state_d  = !adv ? state_q : bus.dir ? state_q - 3'd1 : state_q + 3'd1;
        pulse_d  = adv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= RUN;
            s1_q    <= '0;
            s2_q    <= '0;
            lvl_q   <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            state_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.step_pulse = pulse_q;
    assign bus.running    = mode_q == RUN;
endmodule

// File: tb/tb_ring_step_sequencer.sv
// tb_ring_step_sequencer: directed vectors for ring_step_sequencer with BASE_DIV=8, DEBOUNCE_CYCLES=4.
module tb_ring_step_sequencer;
    localparam int unsigned BASE_DIV = 8;
    localparam int unsigned DEB      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bad;

    ring_step_sequencer_if bus ();

    ring_step_sequencer #(.BASE_DIV(BASE_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en = 1'b1; bus.dir = 1'b0; bus.speed = 2'd0;
        bus.pause_btn = 1'b0; bus.step_btn = 1'b0;
        #12;
        check("rst_state", bus.state, 0);
        check("rst_running", bus.running, 1);
        check("rst_pulse", bus.step_pulse, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        // Run, increment, speed 0: one step every 8 cycles with a wrap at the 64th.
        cyc(7);
        check("t1_pre_state", bus.state, 0);
        check("t1_pre_pulse", bus.step_pulse, 0);
        cyc(1);
        check("t1_first_state", bus.state, 1);
        check("t1_first_pulse", bus.step_pulse, 1);
        for (int k = 2; k <= 8; k++) begin
            cyc(1);
            check("t1_pulse_low", bus.step_pulse, 0);
            cyc(7);
            check("t1_state", bus.state, k % 8);
            check("t1_pulse", bus.step_pulse, 1);
        end
        bus.dir = 1'b1;
        cyc(8);
        check("t2_dec_wrap", bus.state, 7);
        cyc(8);
        check("t2_dec", bus.state, 6);
        bus.speed = 2'd3;
        cyc(1);
        check("t2_div1_a", bus.state, 5);
        check("t2_div1_pulse", bus.step_pulse, 1);
        cyc(1);
        check("t2_div1_b", bus.state, 4);
        bus.speed = 2'd2;
        cyc(1);
        check("t2_div2_hold", bus.state, 4);
        check("t2_div2_nopulse", bus.step_pulse, 0);
        cyc(1);
        check("t2_div2_a", bus.state, 3);
        check("t2_div2_pulse", bus.step_pulse, 1);
        cyc(1);
        check("t2_div2_gap", bus.step_pulse, 0);
        cyc(1);
        check("t2_div2_b", bus.state, 2);
        bus.dir = 1'b0; bus.speed = 2'd0;
        // Pause press accepted on the 6th edge after assertion.
        bus.pause_btn = 1'b1;
        cyc(5);
        check("t3_still_run", bus.running, 1);
        cyc(1);
        check("t3_paused", bus.running, 0);
        check("t3_state", bus.state, 2);
        cyc(4);
        bus.pause_btn = 1'b0;
        bad = 0;
        repeat (100) begin
            cyc(1);
            if (bus.state != 3'd2 || bus.step_pulse || bus.running) bad++;
        end
        check("t3_hold", bad, 0);
        bus.step_btn = 1'b1;
        cyc(5);
        check("t3_step_pre", bus.state, 2);
        cyc(1);
        check("t3_step", bus.state, 3);
        check("t3_step_pulse", bus.step_pulse, 1);
        cyc(1);
        check("t3_step_pulse_end", bus.step_pulse, 0);
        cyc(3);
        bus.step_btn = 1'b0;
        cyc(20);
        check("t3_step_once", bus.state, 3);
        repeat (4) begin
            bus.step_btn = 1'b1; cyc(2);
            bus.step_btn = 1'b0; cyc(2);
        end
        cyc(10);
        check("t4_bounce", bus.state, 3);
        check("t4_bounce_paused", bus.running, 0);
        // Simultaneous pause and step press: pause wins, no step.
        bus.pause_btn = 1'b1; bus.step_btn = 1'b1;
        cyc(5);
        check("t4_both_pre", bus.running, 0);
        cyc(1);
        check("t4_both_run", bus.running, 1);
        check("t4_both_state", bus.state, 3);
        check("t4_both_pulse", bus.step_pulse, 0);
        cyc(1);
        check("t4_both_nostep", bus.state, 3);
        cyc(3);
        bus.pause_btn = 1'b0; bus.step_btn = 1'b0;
        cyc(3);
        check("t4_resume_pre", bus.state, 3);
        cyc(1);
        check("t4_resume", bus.state, 4);
        check("t4_resume_pulse", bus.step_pulse, 1);
        // Freeze at prescaler count 5.
        cyc(5);
        bus.en = 1'b0;
        cyc(20);
        check("t5_frozen", bus.state, 4);
        check("t5_frozen_pulse", bus.step_pulse, 0);
        bus.en = 1'b1;
        cyc(2);
        check("t5_pre", bus.state, 4);
        cyc(1);
        check("t5_step", bus.state, 5);
        check("t5_step_pulse", bus.step_pulse, 1);
        bus.pause_btn = 1'b1;
        cyc(6);
        check("t6_paused", bus.running, 0);
        cyc(4);
        bus.pause_btn = 1'b0;
        cyc(10);
        check("t6_state5", bus.state, 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_state", bus.state, 0);
        check("t6_async_running", bus.running, 1);
        check("t6_async_pulse", bus.step_pulse, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(7);
        check("t6_post_pre", bus.state, 0);
        cyc(1);
        check("t6_post_step", bus.state, 1);
        check("t6_post_pulse", bus.step_pulse, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
